// File: rtl/axis_hs_monitor.sv
// Passive per-lane valid/ready monitor: saturating transfer/stall/starve counters plus windowed throughput.
// Define AXIS_HS_PROTO_CHK_EN to build the valid-withdrawn-before-accept check.
module axis_hs_lane #(
  parameter int CNT_W    = 32,
  parameter int WIN_LOG2 = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_valid,
  input  logic                i_ready,
  input  logic                i_chk,
  input  logic                i_acc_en,
  input  logic                i_win_end,
  output logic [CNT_W-1:0]    o_xfer_cnt,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_starve_cnt,
  output logic [WIN_LOG2:0]   o_win_xfer,
  output logic                o_proto_err
);
  localparam int AW = WIN_LOG2 + 1;

  logic             w_xfer, w_stall, w_starve;
  logic [CNT_W-1:0] r_xfer, r_stall, r_starve;
  logic [AW-1:0]    r_acc, r_win;

  assign w_xfer   =  i_valid &  i_ready;
  assign w_stall  =  i_valid & ~i_ready;
  assign w_starve = ~i_valid &  i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_xfer   <= '0;
      r_stall  <= '0;
      r_starve <= '0;
      r_acc    <= '0;
      r_win    <= '0;
    end else begin
      if (w_xfer   && r_xfer   != '1) r_xfer   <= r_xfer   + CNT_W'(1);
      if (w_stall  && r_stall  != '1) r_stall  <= r_stall  + CNT_W'(1);
      if (w_starve && r_starve != '1) r_starve <= r_starve + CNT_W'(1);
      // accumulator is held at zero whenever the window is not running
      if (!i_acc_en) begin
        r_acc <= '0;
      end else if (i_win_end) begin
        r_win <= r_acc + AW'(w_xfer);
        r_acc <= '0;
      end else begin
        r_acc <= r_acc + AW'(w_xfer);
      end
    end
  end

  assign o_xfer_cnt   = r_xfer;
  assign o_stall_cnt  = r_stall;
  assign o_starve_cnt = r_starve;
  assign o_win_xfer   = r_win;

`ifdef AXIS_HS_PROTO_CHK_EN
  logic r_prev_stall, r_err;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev_stall <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prev_stall <= w_stall;
      if (i_clr)                                  r_err <= 1'b0;
      else if (r_prev_stall && !i_valid && i_chk) r_err <= 1'b1;
    end
  end
  assign o_proto_err = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = i_chk;
  assign o_proto_err  = 1'b0;
`endif
endmodule

module axis_hs_monitor #(
  parameter int NUM_INTFC = 4,
  parameter int CNT_W     = 32,
  parameter int WIN_LOG2  = 12,
  parameter int TCQ       = 1
) (
  input  logic                              user_clk,
  input  logic                              user_reset_n,
  input  logic                              run,
  input  logic                              clr,
  input  logic [NUM_INTFC-1:0]              chk_mask,
  input  logic [NUM_INTFC-1:0]              valid,
  input  logic [NUM_INTFC-1:0]              ready,
  output logic [NUM_INTFC*CNT_W-1:0]        xfer_cnt,
  output logic [NUM_INTFC*CNT_W-1:0]        stall_cnt,
  output logic [NUM_INTFC*CNT_W-1:0]        starve_cnt,
  output logic [NUM_INTFC*(WIN_LOG2+1)-1:0] win_xfer,
  output logic                              win_done,
  output logic [NUM_INTFC-1:0]              proto_err
);
  // registered outputs carry no modelled delay in synthesizable form
  localparam int W_UNUSED_TCQ = TCQ;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              r_state;
  logic [WIN_LOG2-1:0] r_wc;
  logic                r_win_done;
  logic                w_acc_en, w_win_end;

  assign w_acc_en  = (r_state == RUN) && run;
  assign w_win_end = w_acc_en && !clr && (r_wc == '1);

  // run dropping wins over a coincident window end: the partial window is discarded
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      r_state    <= IDLE;
      r_wc       <= '0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wc <= '0;
          if (run) r_state <= RUN;
        end
        RUN: begin
          if (!run) begin
            r_state <= IDLE;
            r_wc    <= '0;
          end else if (clr) begin
            r_wc <= '0;
          end else begin
            r_wc       <= r_wc + WIN_LOG2'(1);
            r_win_done <= w_win_end;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign win_done = r_win_done;

  for (genvar i = 0; i < NUM_INTFC; i++) begin : g_lane
    axis_hs_lane #(.CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2)) u_lane (
      .i_clk        (user_clk),
      .i_rst_n      (user_reset_n),
      .i_clr        (clr),
      .i_valid      (valid[i]),
      .i_ready      (ready[i]),
      .i_chk        (chk_mask[i]),
      .i_acc_en     (w_acc_en),
      .i_win_end    (w_win_end),
      .o_xfer_cnt   (xfer_cnt[i*CNT_W +: CNT_W]),
      .o_stall_cnt  (stall_cnt[i*CNT_W +: CNT_W]),
      .o_starve_cnt (starve_cnt[i*CNT_W +: CNT_W]),
      .o_win_xfer   (win_xfer[i*(WIN_LOG2+1) +: (WIN_LOG2+1)]),
      .o_proto_err  (proto_err[i])
    );
  end
endmodule

// File: doc/axis_hs_monitor.md
# axis_hs_monitor

Passive per-lane valid/ready handshake monitor placed directly downstream of the back-pressure throttle, tapping the throttled valid/ready pairs on their way to the CPM5N side. It counts transfer, stall and starve cycles per lane with saturating counters and snapshots per-window transfer throughput. Optionally it flags protocol violations (valid withdrawn before acceptance) on lanes selected for checking. It drives nothing back into the datapath.

## Interface
Parameters:
- NUM_INTFC, 4, number of monitored lanes (1..16)
- CNT_W, 32, width of each cumulative counter
- WIN_LOG2, 12, window length is 2^WIN_LOG2 cycles (4..20)
- TCQ, 1, clock-to-out delay on registered assignments

Ports:
- user_clk  in  1  single clock; all logic on rising edge
- user_reset_n  in  1  reset, synchronous, active-low
- run  in  1  1 = window timing active; 0 = window logic idle
- clr  in  1  synchronous clear of all counters and sticky errors
- chk_mask  in  NUM_INTFC  per-lane enable for protocol check
- valid  in  NUM_INTFC  throttled valid per lane
- ready  in  NUM_INTFC  throttled ready per lane
- xfer_cnt  out  NUM_INTFC*CNT_W  cycles with valid&ready, lane i at [i*CNT_W +: CNT_W]
- stall_cnt  out  NUM_INTFC*CNT_W  cycles with valid&!ready
- starve_cnt  out  NUM_INTFC*CNT_W  cycles with !valid&ready
- win_xfer  out  NUM_INTFC*(WIN_LOG2+1)  transfers in last completed window
- win_done  out  1  one-cycle pulse when win_xfer updates
- proto_err  out  NUM_INTFC  sticky per-lane protocol error

## Operation
- Cumulative counters: each lane, each cycle, exactly one of xfer/stall/starve increments by 1 or none (!valid&!ready). Saturate at 2^CNT_W-1; no wrap. Count regardless of run.
- clr: all cumulative counters, window accumulators, win_xfer and proto_err go to 0 next cycle; the beat in the clr cycle is not counted. clr has priority over every increment and over error set.
- Window FSM, states IDLE and RUN:
  - IDLE: cycle counter wc=0, accumulators held at 0; run=1 -> RUN.
  - RUN: wc increments each cycle; per-lane accumulator acc (WIN_LOG2+1 bits) adds valid&ready. When wc==2^WIN_LOG2-1: win_xfer <= acc + current beat, acc <= 0, wc <= 0, win_done=1 next cycle. acc cannot overflow (max 2^WIN_LOG2).
  - run=0 in RUN -> IDLE next cycle; partial window discarded, win_xfer keeps last value, no win_done.
  - clr in RUN: wc and acc to 0, stays in RUN (new window starts).
- Reset: all outputs 0, FSM IDLE.

## Timing
- All outputs registered; counters reflect handshake of cycle N at cycle N+1.
- win_done asserts exactly one cycle, the cycle after window end, coincident with new win_xfer; first window after run rises ends 2^WIN_LOG2 cycles after RUN entry.
- run rise: IDLE->RUN one cycle after run sampled 1; wc=0 in first RUN cycle.
- proto_err: set one cycle after the violating cycle; persists until clr or reset.

## Configuration
- AXIS_HS_PROTO_CHK_EN defined: per lane, register prev_stall = valid&!ready; if prev_stall=1 and valid=0 in current cycle and chk_mask[i]=1, set proto_err[i]. chk_mask sampled in the violating cycle.
- Undefined: check logic absent; proto_err tied to 0.
- Lanes with throttle back-pressure enabled must have chk_mask=0 (throttle legitimately withdraws valid).

## Test plan
- Reset then lane0 valid=ready=1 for 10 cycles, others idle -> xfer_cnt[0]=10, stall/starve 0, other lanes all 0.
- WIN_LOG2=4, run=1, lane1 transfers every other cycle -> win_done every 16 cycles, win_xfer[1]=8; run dropped mid-window -> no win_done, win_xfer stays 8.
- CNT_W=4, lane2 valid=1 ready=0 for 20 cycles -> stall_cnt[2] saturates at 15; clr -> 0 next cycle, stall beat in clr cycle not counted.
- Macro on, chk_mask[3]=1: valid=1 ready=0 one cycle then valid=0 -> proto_err[3]=1 one cycle later, stays until clr; repeat with chk_mask[3]=0 -> stays 0.
- Macro off: same violation stimulus -> proto_err all 0.
- user_reset_n low mid-window with counters nonzero -> all outputs 0 next cycle, FSM IDLE, no win_done until run-triggered full window elapses.
